// File: rtl/noc_endpoint_pkg.sv
// noc_endpoint_pkg: flit layout and quiesce states shared by the mesh endpoint
package noc_endpoint_pkg;
  localparam int FLIT_W = 32;
  localparam int ID_W = 4;
  localparam int SEQ_W = 8;
  localparam int PAYLOAD_W = 16;
  typedef struct packed {
    logic [ID_W-1:0] dest;
    logic [ID_W-1:0] src;
    logic [SEQ_W-1:0] seq;
    logic [PAYLOAD_W-1:0] payload;
  } flit_t;
  typedef enum logic [1:0] {Q_RUN, Q_DRAIN, Q_IDLE} q_state_t;
endpackage

// File: rtl/noc_ep_fifo.sv
// noc_ep_fifo: power-of-two synchronous FIFO with valid/ready on both sides
module noc_ep_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_cnt;
  logic w_push, w_pop;
  assign o_ready = r_cnt != (AW+1)'(DEPTH);
  assign o_valid = r_cnt != '0;
  assign o_data = r_mem[r_rd];
  assign w_push = i_valid & o_ready;
  assign w_pop = o_valid & i_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= i_data;
endmodule

// File: rtl/noc_endpoint.sv
// noc_endpoint: host-side mesh endpoint; packs/injects single-flit packets,
// checks and ejects incoming flits, and runs the per-node quiesce handshake.
module noc_endpoint import noc_endpoint_pkg::*; #(
  parameter int NODE_ID = 1,
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_host_tx_valid,
  output logic                 o_host_tx_ready,
  input  logic [ID_W-1:0]      i_host_tx_dest,
  input  logic [PAYLOAD_W-1:0] i_host_tx_payload,
  output logic                 o_net_out_valid,
  input  logic                 i_net_out_ready,
  output logic [FLIT_W-1:0]    o_net_out_flit,
  input  logic                 i_net_in_valid,
  output logic                 o_net_in_ready,
  input  logic [FLIT_W-1:0]    i_net_in_flit,
  output logic                 o_host_rx_valid,
  input  logic                 i_host_rx_ready,
  output logic [ID_W-1:0]      o_host_rx_src,
  output logic [SEQ_W-1:0]     o_host_rx_seq,
  output logic [PAYLOAD_W-1:0] o_host_rx_payload,
  input  logic                 i_quiesce_req,
  output logic                 o_quiesce_ack,
  output logic [15:0]          o_tx_count,
  output logic [15:0]          o_rx_count,
  output logic                 o_err_misroute,
  output logic                 o_err_seq
);
  localparam logic [ID_W-1:0] MY_ID = ID_W'(NODE_ID - 1);
  q_state_t r_state, w_state_nxt;
  logic [SEQ_W-1:0] r_tx_seq [2**ID_W];
  logic [SEQ_W-1:0] r_rx_exp [2**ID_W];
  logic [15:0] r_tx_count, r_rx_count;
  logic r_err_misroute, r_err_seq;
  flit_t w_tx_flit, w_rx_in, w_rx_head;
  logic w_tx_nf, w_rx_nf, w_tx_push, w_rx_push;
  assign w_tx_flit = '{dest: i_host_tx_dest, src: MY_ID, seq: r_tx_seq[i_host_tx_dest], payload: i_host_tx_payload};
  // rst_n gating keeps both readies low while reset is held
  assign o_host_tx_ready = rst_n & (r_state == Q_RUN) & !i_quiesce_req & w_tx_nf;
  assign w_tx_push = i_host_tx_valid & o_host_tx_ready;
  assign w_rx_in = flit_t'(i_net_in_flit);
  assign o_net_in_ready = rst_n & w_rx_nf;
  assign w_rx_push = i_net_in_valid & o_net_in_ready;
  assign o_host_rx_src = w_rx_head.src;
  assign o_host_rx_seq = w_rx_head.seq;
  assign o_host_rx_payload = w_rx_head.payload;
  assign o_tx_count = r_tx_count;
  assign o_rx_count = r_rx_count;
  assign o_err_misroute = r_err_misroute;
  assign o_err_seq = r_err_seq;
  noc_ep_fifo #(.W(FLIT_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n),
    .i_valid(w_tx_push), .o_ready(w_tx_nf), .i_data(w_tx_flit),
    .o_valid(o_net_out_valid), .i_ready(i_net_out_ready), .o_data(o_net_out_flit)
  );
  noc_ep_fifo #(.W(FLIT_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n),
    .i_valid(w_rx_push), .o_ready(w_rx_nf), .i_data(w_rx_in),
    .o_valid(o_host_rx_valid), .i_ready(i_host_rx_ready), .o_data(w_rx_head)
  );
  always_comb begin
    w_state_nxt = r_state;
    o_quiesce_ack = r_state == Q_IDLE;
    if (r_state == Q_RUN) w_state_nxt = i_quiesce_req ? Q_DRAIN : Q_RUN;
    else if (!i_quiesce_req) w_state_nxt = Q_RUN;
    else if (r_state == Q_DRAIN) w_state_nxt = o_net_out_valid ? Q_DRAIN : Q_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= Q_RUN;
      r_tx_count <= '0;
      r_rx_count <= '0;
      r_err_misroute <= 1'b0;
      r_err_seq <= 1'b0;
      for (int i = 0; i < 2**ID_W; i++) begin
        r_tx_seq[i] <= '0;
        r_rx_exp[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      if (w_tx_push) r_tx_seq[i_host_tx_dest] <= r_tx_seq[i_host_tx_dest] + SEQ_W'(1);
      if (o_net_out_valid & i_net_out_ready) r_tx_count <= r_tx_count + 16'd1;
      if (o_host_rx_valid & i_host_rx_ready) r_rx_count <= r_rx_count + 16'd1;
      if (w_rx_push) begin
        if (w_rx_in.dest != MY_ID) r_err_misroute <= 1'b1;
        if (w_rx_in.seq != r_rx_exp[w_rx_in.src]) r_err_seq <= 1'b1;
        r_rx_exp[w_rx_in.src] <= w_rx_in.seq + SEQ_W'(1);
      end
    end
endmodule

// File: tb/tb_noc_endpoint.sv
// tb_noc_endpoint: scoreboard plus table-driven checks of noc_endpoint at NODE_ID=6
module tb_noc_endpoint;
  logic clk = 0, rst_n = 0;
  logic host_tx_valid = 0, host_tx_ready;
  logic [3:0] host_tx_dest = 0;
  logic [15:0] host_tx_payload = 0;
  logic net_out_valid, net_out_ready = 0;
  logic [31:0] net_out_flit;
  logic net_in_valid = 0, net_in_ready;
  logic [31:0] net_in_flit = 0;
  logic host_rx_valid, host_rx_ready = 0;
  logic [3:0] host_rx_src;
  logic [7:0] host_rx_seq;
  logic [15:0] host_rx_payload;
  logic quiesce_req = 0, quiesce_ack;
  logic [15:0] tx_count, rx_count;
  logic err_misroute, err_seq;

  noc_endpoint #(.NODE_ID(6), .TX_DEPTH(4), .RX_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_host_tx_valid(host_tx_valid), .o_host_tx_ready(host_tx_ready),
    .i_host_tx_dest(host_tx_dest), .i_host_tx_payload(host_tx_payload),
    .o_net_out_valid(net_out_valid), .i_net_out_ready(net_out_ready), .o_net_out_flit(net_out_flit),
    .i_net_in_valid(net_in_valid), .o_net_in_ready(net_in_ready), .i_net_in_flit(net_in_flit),
    .o_host_rx_valid(host_rx_valid), .i_host_rx_ready(host_rx_ready),
    .o_host_rx_src(host_rx_src), .o_host_rx_seq(host_rx_seq), .o_host_rx_payload(host_rx_payload),
    .i_quiesce_req(quiesce_req), .o_quiesce_ack(quiesce_ack),
    .o_tx_count(tx_count), .o_rx_count(rx_count),
    .o_err_misroute(err_misroute), .o_err_seq(err_seq)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  logic [31:0] tx_q[$];
  logic [27:0] rx_q[$];
  logic [7:0] m_tx_seq [16];

  typedef struct {
    logic rst_first;
    logic [31:0] flit;
    logic exp_seq;
    logic exp_mis;
  } rx_vec_t;
  rx_vec_t rx_tab[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Transfers are detected half a cycle early; inputs are stable until the next rising edge.
  always @(negedge clk) if (rst_n) begin
    if (host_tx_valid && host_tx_ready) begin
      tx_q.push_back({host_tx_dest, 4'd5, m_tx_seq[host_tx_dest], host_tx_payload});
      m_tx_seq[host_tx_dest] = m_tx_seq[host_tx_dest] + 8'd1;
    end
    if (net_out_valid && net_out_ready) begin
      if (tx_q.size() == 0) check("tx_unexpected", net_out_flit, 32'hxxxxxxxx);
      else check("tx_flit", net_out_flit, tx_q.pop_front());
    end
    if (net_in_valid && net_in_ready) rx_q.push_back(net_in_flit[27:0]);
    if (host_rx_valid && host_rx_ready) begin
      if (rx_q.size() == 0) check("rx_unexpected", {4'd0, host_rx_src, host_rx_seq, host_rx_payload}, 32'hxxxxxxxx);
      else check("rx_pkt", {4'd0, host_rx_src, host_rx_seq, host_rx_payload}, {4'd0, rx_q.pop_front()});
    end
  end

  task automatic reset_assert();
    rst_n = 0;
    tx_q.delete();
    rx_q.delete();
    for (int i = 0; i < 16; i++) m_tx_seq[i] = 0;
  endtask

  task automatic reset_release();
    step(2);
    rst_n = 1;
    step(1);
  endtask

  task automatic tx_send(input logic [3:0] dest, input logic [15:0] pl);
    bit ok = 0;
    host_tx_valid = 1; host_tx_dest = dest; host_tx_payload = pl;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = host_tx_ready;
    end
    step(1);
    host_tx_valid = 0;
    if (!ok) check("tx_send_timeout", 0, 1);
  endtask

  task automatic rx_send(input logic [31:0] f);
    bit ok = 0;
    net_in_valid = 1; net_in_flit = f;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = net_in_ready;
    end
    step(1);
    net_in_valid = 0;
    if (!ok) check("rx_send_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    rx_tab[0] = '{1, 32'h53001111, 0, 0};
    rx_tab[1] = '{0, 32'h53011112, 0, 0};
    rx_tab[2] = '{0, 32'h53031113, 1, 0};
    rx_tab[3] = '{0, 32'h53041114, 1, 0};
    rx_tab[4] = '{1, 32'h53001115, 0, 0};
    rx_tab[5] = '{0, 32'h73011116, 0, 1};
    rx_tab[6] = '{0, 32'h52001117, 0, 1};
    rx_tab[7] = '{0, 32'h53021118, 0, 1};
    rx_tab[8] = '{0, 32'h42001119, 1, 1};
    reset_assert();
    step(2);
    check("rst_tx_ready", host_tx_ready, 0);
    check("rst_net_in_ready", net_in_ready, 0);
    check("rst_valids", {net_out_valid, host_rx_valid, quiesce_ack}, 0);
    check("rst_counts", {tx_count, rx_count}, 0);
    check("rst_errs", {err_misroute, err_seq}, 0);
    reset_release();
    host_rx_ready = 1;

    net_out_ready = 1;
    tx_send(4'd10, 16'hBEEF);
    check("t1_valid", net_out_valid, 1);
    check("t1_flit", net_out_flit, 32'hA500BEEF);
    tx_send(4'd10, 16'h0001);
    check("t1_flit2", net_out_flit, 32'hA5010001);
    step(3);
    check("t1_tx_count", tx_count, 2);

    net_out_ready = 0;
    for (int i = 0; i < 4; i++) tx_send(4'd3, 16'(i));
    host_tx_valid = 1; host_tx_dest = 4'd3; host_tx_payload = 16'd4;
    step(2);
    check("full_tx_ready", host_tx_ready, 0);
    check("full_head", net_out_flit, 32'h35000000);
    net_out_ready = 1;
    ok = 0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = host_tx_ready;
    end
    step(1);
    host_tx_valid = 0;
    check("full_fifth_accepted", ok, 1);
    step(8);
    check("full_tx_count", tx_count, 7);

    net_out_ready = 0;
    for (int i = 0; i < 3; i++) tx_send(4'd1, 16'h100 + 16'(i));
    quiesce_req = 1;
    step(1);
    check("q_tx_ready", host_tx_ready, 0);
    check("q_ack_early", quiesce_ack, 0);
    step(3);
    check("q_ack_drain", quiesce_ack, 0);
    net_out_ready = 1;
    ok = 0;
    for (int k = 0; k < 20 && !ok; k++) begin
      step(1);
      ok = quiesce_ack;
    end
    check("q_ack_idle", quiesce_ack, 1);
    check("q_drained", net_out_valid, 0);
    quiesce_req = 0;
    step(1);
    check("q_ack_drop", quiesce_ack, 0);
    check("q_run_ready", host_tx_ready, 1);
    net_out_ready = 0;
    tx_send(4'd1, 16'h200);
    quiesce_req = 1;
    step(2);
    quiesce_req = 0;
    step(1);
    check("q_abort_ready", host_tx_ready, 1);
    check("q_abort_ack", quiesce_ack, 0);
    net_out_ready = 1;
    step(3);

    foreach (rx_tab[i]) begin
      if (rx_tab[i].rst_first) begin
        reset_assert();
        reset_release();
      end
      rx_send(rx_tab[i].flit);
      check($sformatf("rx%0d_err_seq", i), err_seq, rx_tab[i].exp_seq);
      check($sformatf("rx%0d_err_mis", i), err_misroute, rx_tab[i].exp_mis);
    end
    step(3);
    check("rx_count", rx_count, 5);

    tx_send(4'd2, 16'h0);
    step(2);
    net_out_ready = 0;
    host_rx_ready = 0;
    tx_send(4'd10, 16'hAAAA);
    tx_send(4'd10, 16'hBBBB);
    rx_send(32'h55001234);
    rx_send(32'h55011235);
    check("pre_rst_counts", {tx_count, rx_count}, {16'd1, 16'd5});
    reset_assert();
    #1;
    check("mid_rst_valids", {net_out_valid, host_rx_valid}, 0);
    check("mid_rst_readies", {host_tx_ready, net_in_ready}, 0);
    check("mid_rst_counts", {tx_count, rx_count}, 0);
    reset_release();
    step(2);
    check("post_rst_no_stale", {net_out_valid, host_rx_valid}, 0);
    tx_send(4'd10, 16'h1234);
    check("post_rst_seq0", net_out_flit, 32'hA5001234);
    net_out_ready = 1;
    host_rx_ready = 1;
    step(5);
    check("tx_q_empty", tx_q.size(), 0);
    check("rx_q_empty", rx_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
